transconv_psum_accumulator: RTL

- Downstream stage of the unified conv/transconv compute top in TRANSCONV mode.
- Consumes the serial partial-sum stream (result, column id, partial-valid) and overlap-adds partials that land on the same output column into a per-column accumulator bank.
- On flush, drains the finished, saturated column results in column order over a valid/ready handshake toward the output BRAM writer.

---
 rtl/transconv_psum_accumulator.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/transconv_psum_accumulator.sv
// Overlap-add accumulator for the transconv partial-sum stream.
// Partials landing on the same output column are summed into a per-column
// bank; on flush the bank is drained in column order, saturated to DW bits.
module transconv_psum_accumulator #(
    parameter int DW        = 16,
    parameter int Dimension = 16,
    parameter int ACC_W     = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          flush,
    input  logic          partial_valid,
    input  logic [DW-1:0] result_in,
    input  logic [3:0]    col_id,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_col,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          sat_flag,
    output logic          drop_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q [Dimension];
    logic signed [ACC_W-1:0]  acc_d [Dimension];
    logic [3:0]               ptr_q, ptr_d;
    logic                     sat_q, sat_d;
    logic                     drop_q, drop_d;

    logic signed [ACC_W-1:0]  ext;
    logic signed [ACC_W-1:0]  rd_acc;
    logic                     clip_hi, clip_lo;
    logic [DW-1:0]            sat_val;
    logic                     in_range;
    logic                     xfer;

    assign ext      = {{(ACC_W-DW){result_in[DW-1]}}, result_in};
    assign in_range = ({1'b0, col_id} < 5'(Dimension));
    assign xfer     = (state_q == S_DRAIN) && out_ready;

    // Select the column under the drain pointer and saturate it to DW bits
    always_comb begin
        rd_acc = '0;
        for (int unsigned i = 0; i < Dimension; i++) begin
            if (ptr_q == 4'(i)) rd_acc = acc_q[i];
        end
        clip_hi = (rd_acc > SAT_MAX);
        clip_lo = (rd_acc < SAT_MIN);
        if (clip_hi)      sat_val = SAT_MAX[DW-1:0];
        else if (clip_lo) sat_val = SAT_MIN[DW-1:0];
        else              sat_val = rd_acc[DW-1:0];
    end

    // Next-state logic for the FSM, accumulator bank, drain pointer and sticky flags
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        sat_d   = sat_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    sat_d   = 1'b0;
                    drop_d  = 1'b0;
                end
                if (partial_valid) drop_d = 1'b1;
            end
            S_CLEAR: begin
                for (int unsigned i = 0; i < Dimension; i++) acc_d[i] = '0;
                ptr_d   = '0;
                state_d = S_ACCUM;
                if (partial_valid) drop_d = 1'b1;
            end
            S_ACCUM: begin
                if (partial_valid) begin
                    if (in_range) begin
                        for (int unsigned i = 0; i < Dimension; i++) begin
                            if (col_id == 4'(i)) acc_d[i] = acc_q[i] + ext;
                        end
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                if (flush) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (partial_valid) drop_d = 1'b1;
                if (xfer) begin
                    if (clip_hi || clip_lo) sat_d = 1'b1;
                    if (ptr_q == 4'(Dimension-1)) begin
                        ptr_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        ptr_d = ptr_q + 4'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
            for (int unsigned i = 0; i < Dimension; i++) acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
            acc_q   <= acc_d;
        end
    end

    assign out_valid = (state_q == S_DRAIN);
    assign out_col   = out_valid ? ptr_q : '0;
    assign out_data  = out_valid ? sat_val : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sat_flag  = sat_q;
    assign drop_err  = drop_q;

endmodule
